muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_ctrl.sv | 178 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Pipeline-side bundle for the multi-cycle MULTU/DIVU controller.
//   master : EX-stage pipeline (drives requests, consumes stall/Hi-Lo writes)
//   slave  : muldiv_ctrl
// Signals:
//   start, op[1:0], src_a, src_b, mf_req        pipeline -> controller
//   busy, stall, hilo_signal[1:0], result, done controller -> pipeline / Hi-Lo
// -----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     src_a;
    logic [WIDTH-1:0]     src_b;
    logic                 mf_req;
    logic                 busy;
    logic                 stall;
    logic [1:0]           hilo_signal;
    logic [2*WIDTH-1:0]   result;
    logic                 done;

    modport master (
        output start, op, src_a, src_b, mf_req,
        input  busy, stall, hilo_signal, result, done
    );

    modport slave (
        input  start, op, src_a, src_b, mf_req,
        output busy, stall, hilo_signal, result, done
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Iterative unsigned MULTU (shift-add) / DIVU (restoring) sequencer sitting
// beside the Hi/Lo register in EX. Produces the Hi/Lo write control and the
// {Hi,Lo} value, and stalls the front end so that no new mul/div or MFHI/MFLO
// can observe Hi/Lo before the write lands.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : muldiv_if.slave (start/op/src_a/src_b/mf_req in,
//            busy/stall/hilo_signal/result/done out)
// Build option:
//   MULDIV_EARLY_OUT_EN - when defined, MUL finishes early once every
//   multiplier bit still to be consumed is zero. Results are identical.
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0]       OP_MULTU  = 2'b01;
    localparam logic [1:0]       OP_DIVU   = 2'b10;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    // MUL: {upper product, remaining multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    // multiplicand for MUL, divisor for DIV
    logic [WIDTH-1:0]     opnd_r, opnd_s;
    logic [1:0]           op_r, op_s;
    logic [2*WIDTH-1:0]   result_r, result_s;
    logic                 busy_r, done_r;
    logic [1:0]           hilo_r;

    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_step_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_step_s;
    logic                 early_s;
    logic [2*WIDTH-1:0]   early_acc_s;

    // One shift-add step: the carry out of the upper-half add becomes the new MSB.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    assign mul_step_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]}
                                 : {1'b0, acc_r[2*WIDTH-1:1]};

    // One restoring step: shift {rem,quot} left, trial-subtract; MSB of the
    // difference is the borrow.
    assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_step_s  = div_diff_s[WIDTH]
                       ? {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                       : {div_diff_s[WIDTH-1:0],  acc_r[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
    // After cnt_r steps the unconsumed multiplier bits sit in acc_r[WIDTH-1-cnt_r:0];
    // if they are all zero the remaining steps are pure shifts.
    assign early_s     = (acc_r[WIDTH-1:0] & ({WIDTH{1'b1}} >> cnt_r)) == {WIDTH{1'b0}};
    assign early_acc_s = acc_r >> (WIDTH_CNT - cnt_r);
`else
    assign early_s     = 1'b0;
    assign early_acc_s = acc_r;
`endif

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        opnd_s   = opnd_r;
        op_s     = op_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (bus.start && (bus.op == OP_MULTU)) begin
                    state_s = MUL;
                    acc_s   = {{WIDTH{1'b0}}, bus.src_b};
                    opnd_s  = bus.src_a;
                    op_s    = bus.op;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (bus.start && (bus.op == OP_DIVU)) begin
                    op_s = bus.op;
                    if (bus.src_b != {WIDTH{1'b0}}) begin
                        state_s = DIV;
                        acc_s   = {{WIDTH{1'b0}}, bus.src_a};
                        opnd_s  = bus.src_b;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        // Divide by zero: Hi = dividend, Lo = all ones, no iteration.
                        state_s  = DONE;
                        result_s = {bus.src_a, {WIDTH{1'b1}}};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (early_s) begin
                    state_s  = DONE;
                    acc_s    = early_acc_s;
                    result_s = early_acc_s;
                end else if (cnt_r == LAST_CNT) begin
                    state_s  = DONE;
                    acc_s    = mul_step_s;
                    result_s = mul_step_s;
                end else begin
                    acc_s = mul_step_s;
                end
            end
            DIV: begin
                cnt_s = cnt_r + CNT_W'(1);
                acc_s = div_step_s;
                if (cnt_r == LAST_CNT) begin
                    state_s  = DONE;
                    result_s = div_step_s;
                end else begin
                    state_s = DIV;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; synchronous reset aborts any
    // operation without a Hi/Lo write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            op_r     <= 2'b00;
            result_r <= {(2*WIDTH){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hilo_r   <= 2'b00;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            acc_r    <= acc_s;
            opnd_r   <= opnd_s;
            op_r     <= op_s;
            result_r <= result_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
            hilo_r   <= (state_s == DONE) ? op_s : 2'b00;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hilo_signal = hilo_r;
    assign bus.result      = result_r;
    // DONE is included: Hi/Lo only captures at the end of that cycle. In IDLE an
    // accompanying mf instruction is older and reads the current Hi/Lo.
    assign bus.stall       = busy_r & (bus.start | bus.mf_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed self-checking bench for muldiv_ctrl. Inputs are driven and outputs
// sampled on the falling clock edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one op from IDLE; lat = cycle index after the accept edge at which
    // done is seen (0 on timeout). Returns at the falling edge of the DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 2'b00;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) lat = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'h0; bus.src_b = 32'h0;
        bus.mf_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 ||
            bus.hilo_signal !== 2'b00 || bus.result !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall=%b done=%b hilo=%b result=%h, want all zero",
                     bus.busy, bus.stall, bus.done, bus.hilo_signal, bus.result);
        end
        reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== 33) begin
            errors++; $display("FAIL mul_latency: got %0d want 33", lat);
        end
        checks++;
        if (bus.hilo_signal !== 2'b01 || bus.result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL mul_max_result: hilo=%b result=%h want 01 fffffffe00000001",
                     bus.hilo_signal, bus.result);
        end
        @(negedge clk);
        checks++;
        if (bus.hilo_signal !== 2'b00 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_after_done: hilo=%b done=%b busy=%b want 00 0 0",
                     bus.hilo_signal, bus.done, bus.busy);
        end
    endtask

    task automatic test_divu();
        int lat;
        run_op(2'b10, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33 || bus.hilo_signal !== 2'b10 ||
            bus.result !== 64'h0000_0002_0000_000E) begin
            errors++;
            $display("FAIL div_100_7: lat=%0d hilo=%b result=%h want 33 10 000000020000000e",
                     lat, bus.hilo_signal, bus.result);
        end
        run_op(2'b10, 32'd5, 32'd0, lat);
        checks++;
        if (lat !== 1 || bus.hilo_signal !== 2'b10 ||
            bus.result !== 64'h0000_0005_FFFF_FFFF) begin
            errors++;
            $display("FAIL div_by_zero: lat=%0d hilo=%b result=%h want 1 10 00000005ffffffff",
                     lat, bus.hilo_signal, bus.result);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.hilo_signal !== 2'b00) begin
            errors++;
            $display("FAIL div0_after_done: done=%b hilo=%b want 0 00", bus.done, bus.hilo_signal);
        end
        run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, lat);
        checks++;
        if (lat !== 33 || bus.result !== 64'h0000_000F_0FFF_FFFF) begin
            errors++;
            $display("FAIL div_max_16: lat=%0d result=%h want 33 0000000f0fffffff",
                     lat, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_mf_stall();
        int cyc;
        int bad;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd6; bus.src_b = 32'd7;
        @(negedge clk);               // cycle 1
        bus.start = 1'b0; bus.op = 2'b00;
        cyc = 1;
        bad = 0;
        // mf_req from cycle 2 through the DONE cycle
        do begin
            @(negedge clk);
            cyc++;
            bus.mf_req = 1'b1;
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL mf_stall: cycle %0d stall=%b want 1", cyc, bus.stall);
            end
        end while (bus.done !== 1'b1 && cyc < 100);
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL mf_done_cycle: got %0d want 33", cyc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.result !== 64'h0000_0000_0000_002A) begin
            errors++;
            $display("FAIL mf_release: stall=%b result=%h want 0 000000000000002a",
                     bus.stall, bus.result);
        end
        bus.mf_req = 1'b0;
    endtask

    task automatic test_idle_start_mf();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'd11;
        bus.mf_req = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL idle_start_mf_stall: stall=%b want 0", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.op = 2'b00; bus.mf_req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL idle_start_mf_accept: busy=%b want 1", bus.busy);
        end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.result !== 64'd99) begin
            errors++; $display("FAIL idle_start_mf_result: result=%h want 63", bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd10;
        @(negedge clk);               // cycle 1
        bus.start = 1'b0; bus.op = 2'b00;
        cyc = 1;
        bad = 0;
        repeat (3) begin @(negedge clk); cyc++; end   // cycle 4
        do begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd4;
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL b2b_stall: cycle %0d stall=%b want 1", cyc, bus.stall);
            end
        end while (bus.done !== 1'b1 && cyc < 100);
        checks++;
        if (cyc !== 33 || bus.hilo_signal !== 2'b10 ||
            bus.result !== 64'h0000_0000_0000_0064) begin
            errors++;
            $display("FAIL b2b_div_result: cycle=%0d hilo=%b result=%h want 33 10 0000000000000064",
                     cyc, bus.hilo_signal, bus.result);
        end
        @(negedge clk);               // first IDLE cycle, start still held
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: stall=%b busy=%b want 0 0", bus.stall, bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.op = 2'b00;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 33 || bus.hilo_signal !== 2'b01 ||
            bus.result !== 64'h0000_0000_0000_000C) begin
            errors++;
            $display("FAIL b2b_mul_result: cycle=%0d hilo=%b result=%h want 33 01 000000000000000c",
                     cyc, bus.hilo_signal, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9;
        @(negedge clk);               // cycle 1
        bus.start = 1'b0; bus.op = 2'b00;
        repeat (9) @(negedge clk);    // cycle 10
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hilo_signal !== 2'b00 || bus.done !== 1'b0 ||
            bus.result !== 64'h0) begin
            errors++;
            $display("FAIL abort_state: busy=%b hilo=%b done=%b result=%h want 0 00 0 0",
                     bus.busy, bus.hilo_signal, bus.done, bus.result);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.hilo_signal !== 2'b00) seen++;
            if (i == 5) begin bus.start = 1'b1; bus.op = 2'b00; end
            if (i == 6) begin bus.op = 2'b11; end
            if (i == 7) begin bus.start = 1'b0; end
        end
        checks++;
        if (seen !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: spurious write cycles=%0d busy=%b want 0 0", seen, bus.busy);
        end
        run_op(2'b01, 32'h1234_5678, 32'h9, lat);
        checks++;
        if (lat !== 33 || bus.result !== 64'h0000_0000_A3D7_0A38) begin
            errors++;
            $display("FAIL abort_rerun: lat=%0d result=%h want 33 00000000a3d70a38",
                     lat, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_early_out();
        int lat;
        run_op(2'b01, 32'h10, 32'h3, lat);
        checks++;
        if (bus.result !== 64'h30 || bus.hilo_signal !== 2'b01) begin
            errors++;
            $display("FAIL early_result: result=%h hilo=%b want 30 01", bus.result, bus.hilo_signal);
        end
        checks++;
`ifdef MULDIV_EARLY_OUT_EN
        if (lat < 1 || lat > 4) begin
            errors++; $display("FAIL early_latency: got %0d want 1..4", lat);
        end
`else
        if (lat !== 33) begin
            errors++; $display("FAIL early_latency: got %0d want 33", lat);
        end
`endif
        @(negedge clk);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h0, lat);
        checks++;
        if (bus.result !== 64'h0 || lat < 1) begin
            errors++; $display("FAIL mul_by_zero: result=%h lat=%0d want 0", bus.result, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_divu();
        test_mf_stall();
        test_idle_start_mf();
        test_back_to_back();
        test_reset_abort();
        test_early_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
